// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared types and constants for the PC redirect controller.
//   state_t     : controller state (IDLE / PEND / EXC)
//   prio_t      : 2-bit redirect priority, higher value wins
//   PRIO_*      : priority of each redirect source
//   DEFAULT_EXC_VECTOR / RESET_VECTOR : fixed PC targets
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    EXC  = 2'd2
  } state_t;

  typedef logic [1:0] prio_t;

  localparam prio_t PRIO_EXC = 2'd3;
  localparam prio_t PRIO_BR  = 2'd2;
  localparam prio_t PRIO_JR  = 2'd1;
  localparam prio_t PRIO_J   = 2'd0;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] RESET_VECTOR       = 32'hBFC0_0000;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if
// Bundles the handshake between the redirect requesters / hazard unit /
// instruction memory and the PC sequencing controller.
//   master : the surrounding pipeline (drives requests, stall, imemReady)
//   slave  : the controller (drives PC load / redirect / status outputs)
interface pc_redirect_ctrl_if;
  import pc_ctrl_pkg::*;

  logic        stall;
  logic        imemReady;
  logic        excReq;
  logic        branchReq;
  logic [31:0] branchTarget;
  logic        jumpRegReq;
  logic [31:0] jumpRegTarget;
  logic        jumpImmReq;
  logic [31:0] jumpImmTarget;

  logic        pcWrite;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        excTaken;
  logic        flushPipe;
  logic        busy;

  modport master (
    output stall, imemReady,
    output excReq, branchReq, branchTarget,
    output jumpRegReq, jumpRegTarget, jumpImmReq, jumpImmTarget,
    input  pcWrite, redirect, redirectTarget, excTaken, flushPipe, busy
  );

  modport slave (
    input  stall, imemReady,
    input  excReq, branchReq, branchTarget,
    input  jumpRegReq, jumpRegTarget, jumpImmReq, jumpImmTarget,
    output pcWrite, redirect, redirectTarget, excTaken, flushPipe, busy
  );

endinterface

// File: rtl/redirect_prio_enc.sv
// redirect_prio_enc
// Combinational priority encoder over the four redirect requests.
//   exc_req/br_req/jr_req/j_req : request strobes (exception highest)
//   br_target/jr_target/j_target: targets qualified by their request
//   valid  : any request asserted
//   prio   : priority of the winning request
//   target : target of the winning request (EXC_VECTOR for exceptions)
module redirect_prio_enc
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc_req,
  input  logic        br_req,
  input  logic        jr_req,
  input  logic        j_req,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] j_target,
  output logic        valid,
  output prio_t       prio,
  output logic [31:0] target
);

  // Requests and targets indexed by their priority value.
  logic [3:0]  req_vec;
  logic [31:0] tgt_arr [4];
  logic [3:0]  higher;
  logic [3:0]  grant;

  assign req_vec[PRIO_EXC] = exc_req;
  assign req_vec[PRIO_BR]  = br_req;
  assign req_vec[PRIO_JR]  = jr_req;
  assign req_vec[PRIO_J]   = j_req;

  assign tgt_arr[PRIO_EXC] = EXC_VECTOR;
  assign tgt_arr[PRIO_BR]  = br_target;
  assign tgt_arr[PRIO_JR]  = jr_target;
  assign tgt_arr[PRIO_J]   = j_target;

  // A request is granted only if nothing above it is asserted, so at most
  // one grant bit is ever set.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grant
      if (gi == 3) begin : g_top
        assign higher[gi] = 1'b0;
      end else begin : g_lower
        assign higher[gi] = |req_vec[3:gi+1];
      end
      assign grant[gi] = req_vec[gi] & ~higher[gi];
    end
  endgenerate

  always_comb begin
    valid  = |req_vec;
    prio   = PRIO_J;
    target = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) begin
        prio   = prio_t'(i);
        target = tgt_arr[i];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Holds the highest-priority redirect request until fetch can accept it and
// drives the PC load enable, redirect strobe and registered target.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : pc_redirect_ctrl_if.slave
//          in : stall, imemReady, excReq, branchReq/Target,
//               jumpRegReq/Target, jumpImmReq/Target
//          out: pcWrite, redirect, redirectTarget, excTaken, flushPipe, busy
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic                clk,
  input  logic                rst,
  pc_redirect_ctrl_if.slave   bus
);

  state_t      state_reg;
  logic [31:0] target_reg;
  prio_t       prio_reg;
  logic        flush_reg;

  logic        req_valid;
  prio_t       req_prio;
  logic [31:0] req_target;
  logic        accept;
  logic        latch_en;
  logic        go_idle;

  redirect_prio_enc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_prio_enc (
    .exc_req   (bus.excReq),
    .br_req    (bus.branchReq),
    .jr_req    (bus.jumpRegReq),
    .j_req     (bus.jumpImmReq),
    .br_target (bus.branchTarget),
    .jr_target (bus.jumpRegTarget),
    .j_target  (bus.jumpImmTarget),
    .valid     (req_valid),
    .prio      (req_prio),
    .target    (req_target)
  );

  assign accept = !bus.stall && bus.imemReady;

  // Decide whether this cycle latches the incoming request or retires the
  // pending one. While an exception is latched all requests are ignored,
  // including in its accept cycle.
  always_comb begin
    latch_en = 1'b0;
    go_idle  = 1'b0;
    case (state_reg)
      IDLE: latch_en = req_valid;
      PEND: begin
        if (accept) begin
          latch_en = req_valid;
          go_idle  = !req_valid;
        end else begin
          latch_en = req_valid && (req_prio > prio_reg);
        end
      end
      EXC:     go_idle = accept;
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      prio_reg   <= PRIO_J;
      flush_reg  <= 1'b0;
    end else begin
      flush_reg <= 1'b0;
      if (latch_en) begin
        target_reg <= req_target;
        prio_reg   <= req_prio;
        if (req_prio == PRIO_EXC) begin
          state_reg <= EXC;
          // Entry into EXC only happens from IDLE/PEND, so this marks the
          // first EXC cycle.
          flush_reg <= 1'b1;
        end else begin
          state_reg <= PEND;
        end
      end else if (go_idle) begin
        state_reg <= IDLE;
      end
    end
  end

  // pcWrite follows the accept condition even during reset; the redirect
  // and exception strobes are suppressed while reset discards the pending
  // redirect so nothing is reported as taken.
  assign bus.pcWrite        = accept;
  assign bus.redirect       = accept && (state_reg != IDLE) && rst;
  assign bus.excTaken       = accept && (state_reg == EXC) && rst;
  assign bus.flushPipe      = flush_reg;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.redirectTarget = target_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
  import pc_ctrl_pkg::*;

  localparam logic [31:0] EXCV = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what redirect is outstanding, described by the spec's
  // rules (kind of request, its rank, its target).
  bit          m_busy  = 0;
  bit          m_exc   = 0;
  int          m_rank  = 0;
  logic [31:0] m_tgt   = '0;
  bit          m_flush = 0;

  task automatic model_step();
    int          rank;
    logic [31:0] tgt;
    bit          acc;
    bit          take;
    rank = -1;
    tgt  = '0;
    if (bus.excReq)          begin rank = 3; tgt = EXCV; end
    else if (bus.branchReq)  begin rank = 2; tgt = bus.branchTarget; end
    else if (bus.jumpRegReq) begin rank = 1; tgt = bus.jumpRegTarget; end
    else if (bus.jumpImmReq) begin rank = 0; tgt = bus.jumpImmTarget; end
    acc  = !bus.stall && bus.imemReady;
    take = 0;
    if (!rst) begin
      m_busy = 0; m_exc = 0; m_rank = 0; m_tgt = '0; m_flush = 0;
    end else begin
      if (!m_busy) take = (rank >= 0);
      else if (m_exc) begin
        if (acc) m_busy = 0;
      end else if (acc) begin
        if (rank >= 0) take = 1;
        else m_busy = 0;
      end else if (rank > m_rank) take = 1;
      m_flush = take && (rank == 3);
      if (take) begin
        m_busy = 1; m_exc = (rank == 3); m_rank = rank; m_tgt = tgt;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_reqs();
    bus.excReq = 0; bus.branchReq = 0; bus.jumpRegReq = 0; bus.jumpImmReq = 0;
    bus.branchTarget = '0; bus.jumpRegTarget = '0; bus.jumpImmTarget = '0;
  endtask

  task automatic test_reset();
    rst = 0; bus.stall = 0; bus.imemReady = 1; clear_reqs();
    tick(); tick();
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.redirectTarget !== 32'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", bus.redirectTarget); end
    checks++; if (bus.flushPipe !== 1'b0 || bus.excTaken !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.flushPipe, bus.excTaken); end
    checks++; if (bus.redirect !== 1'b0 || bus.pcWrite !== 1'b1) begin failures++; $display("FAIL reset_pc got redirect=%b pcWrite=%b exp 0/1", bus.redirect, bus.pcWrite); end
    rst = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_branch();
    bus.stall = 0; bus.imemReady = 1;
    bus.branchReq = 1; bus.branchTarget = 32'h3040;
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL branch_t_busy got=%b exp=0", bus.busy); end
    tick(); clear_reqs(); #2;
    checks++; if (bus.busy !== 1'b1 || bus.redirect !== 1'b1 || bus.pcWrite !== 1'b1) begin failures++; $display("FAIL branch_t1 got busy=%b redirect=%b pcWrite=%b exp 1/1/1", bus.busy, bus.redirect, bus.pcWrite); end
    checks++; if (bus.redirectTarget !== 32'h3040) begin failures++; $display("FAIL branch_target got=%h exp=3040", bus.redirectTarget); end
    tick(); #2;
    checks++; if (bus.busy !== 1'b0 || bus.redirect !== 1'b0) begin failures++; $display("FAIL branch_t2 got busy=%b redirect=%b exp 0/0", bus.busy, bus.redirect); end
    $display("test_branch done");
  endtask

  task automatic test_stall();
    bus.stall = 0; bus.imemReady = 1;
    bus.jumpImmReq = 1; bus.jumpImmTarget = 32'h3100;
    tick(); clear_reqs(); bus.stall = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++; if (bus.pcWrite !== 1'b0 || bus.redirect !== 1'b0 || bus.busy !== 1'b1 || bus.redirectTarget !== 32'h3100) begin
        failures++; $display("FAIL stall_hold cyc=%0d got pcWrite=%b redirect=%b busy=%b tgt=%h exp 0/0/1/3100", i, bus.pcWrite, bus.redirect, bus.busy, bus.redirectTarget);
      end
      tick();
    end
    bus.stall = 0; bus.imemReady = 0; #2;
    checks++; if (bus.pcWrite !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL stall_imem got pcWrite=%b busy=%b exp 0/1", bus.pcWrite, bus.busy); end
    tick(); bus.imemReady = 1; #2;
    checks++; if (bus.redirect !== 1'b1 || bus.pcWrite !== 1'b1 || bus.redirectTarget !== 32'h3100) begin failures++; $display("FAIL stall_accept got redirect=%b pcWrite=%b tgt=%h exp 1/1/3100", bus.redirect, bus.pcWrite, bus.redirectTarget); end
    tick(); #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stall_done got busy=%b exp=0", bus.busy); end
    $display("test_stall done");
  endtask

  task automatic test_override();
    bus.stall = 1; bus.imemReady = 1;
    bus.jumpImmReq = 1; bus.jumpImmTarget = 32'h3100;
    tick(); clear_reqs();
    bus.branchReq = 1; bus.branchTarget = 32'h3200;
    tick(); clear_reqs(); #2;
    checks++; if (bus.redirectTarget !== 32'h3200) begin failures++; $display("FAIL override_br got=%h exp=3200", bus.redirectTarget); end
    bus.jumpImmReq = 1; bus.jumpImmTarget = 32'h3300;
    tick(); clear_reqs(); #2;
    checks++; if (bus.redirectTarget !== 32'h3200 || bus.busy !== 1'b1) begin failures++; $display("FAIL override_drop got tgt=%h busy=%b exp 3200/1", bus.redirectTarget, bus.busy); end
    bus.stall = 0; #2;
    checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL override_accept got=%b exp=1", bus.redirect); end
    tick(); #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL override_done got busy=%b exp=0", bus.busy); end
    $display("test_override done");
  endtask

  task automatic test_exception();
    bus.stall = 1; bus.imemReady = 1;
    bus.branchReq = 1; bus.branchTarget = 32'h3040;
    tick(); clear_reqs(); #2;
    checks++; if (bus.flushPipe !== 1'b0) begin failures++; $display("FAIL exc_noflush got=%b exp=0", bus.flushPipe); end
    bus.excReq = 1;
    tick(); clear_reqs(); #2;
    checks++; if (bus.redirectTarget !== EXCV || bus.flushPipe !== 1'b1 || bus.excTaken !== 1'b0) begin
      failures++; $display("FAIL exc_entry got tgt=%h flush=%b excTaken=%b exp bfc00380/1/0", bus.redirectTarget, bus.flushPipe, bus.excTaken);
    end
    bus.branchReq = 1; bus.branchTarget = 32'h3600;
    tick(); clear_reqs(); #2;
    checks++; if (bus.redirectTarget !== EXCV || bus.flushPipe !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL exc_ignore got tgt=%h flush=%b busy=%b exp bfc00380/0/1", bus.redirectTarget, bus.flushPipe, bus.busy);
    end
    bus.stall = 0; #2;
    checks++; if (bus.excTaken !== 1'b1 || bus.redirect !== 1'b1) begin failures++; $display("FAIL exc_accept got excTaken=%b redirect=%b exp 1/1", bus.excTaken, bus.redirect); end
    tick(); #2;
    checks++; if (bus.busy !== 1'b0 || bus.excTaken !== 1'b0) begin failures++; $display("FAIL exc_done got busy=%b excTaken=%b exp 0/0", bus.busy, bus.excTaken); end
    $display("test_exception done");
  endtask

  task automatic test_back_to_back();
    bus.stall = 0; bus.imemReady = 1;
    bus.branchReq = 1; bus.branchTarget = 32'h3040;
    tick(); clear_reqs();
    bus.jumpRegReq = 1; bus.jumpRegTarget = 32'h3500; #2;
    checks++; if (bus.redirect !== 1'b1 || bus.redirectTarget !== 32'h3040) begin failures++; $display("FAIL b2b_accept got redirect=%b tgt=%h exp 1/3040", bus.redirect, bus.redirectTarget); end
    tick(); clear_reqs(); bus.stall = 1; #2;
    checks++; if (bus.busy !== 1'b1 || bus.redirectTarget !== 32'h3500) begin failures++; $display("FAIL b2b_next got busy=%b tgt=%h exp 1/3500", bus.busy, bus.redirectTarget); end
    bus.stall = 0;
    tick(); #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_done got busy=%b exp=0", bus.busy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    bus.stall = 1; bus.imemReady = 1;
    bus.excReq = 1;
    tick(); clear_reqs(); #2;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got busy=%b exp=1", bus.busy); end
    rst = 0;
    tick(); rst = 1; bus.stall = 0; #2;
    checks++; if (bus.busy !== 1'b0 || bus.redirectTarget !== 32'h0 || bus.excTaken !== 1'b0 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL rstmid_post got busy=%b tgt=%h excTaken=%b redirect=%b exp 0/0/0/0", bus.busy, bus.redirectTarget, bus.excTaken, bus.redirect);
    end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = failures;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.stall         = ($urandom_range(0, 99) < 30);
      bus.imemReady     = ($urandom_range(0, 99) < 80);
      bus.excReq        = ($urandom_range(0, 99) < 6);
      bus.branchReq     = ($urandom_range(0, 99) < 25);
      bus.jumpRegReq    = ($urandom_range(0, 99) < 25);
      bus.jumpImmReq    = ($urandom_range(0, 99) < 25);
      bus.branchTarget  = $urandom;
      bus.jumpRegTarget = $urandom;
      bus.jumpImmTarget = $urandom;
      #2;
      checks++;
      if (bus.pcWrite !== (!bus.stall && bus.imemReady) ||
          bus.redirect !== (!bus.stall && bus.imemReady && m_busy) ||
          bus.excTaken !== (!bus.stall && bus.imemReady && m_busy && m_exc) ||
          bus.flushPipe !== m_flush || bus.busy !== m_busy ||
          (m_busy && bus.redirectTarget !== m_tgt)) begin
        failures++;
        $display("FAIL random cyc=%0d got pw=%b rd=%b et=%b fl=%b bz=%b tgt=%h exp bz=%b exc=%b fl=%b tgt=%h",
                 cyc, bus.pcWrite, bus.redirect, bus.excTaken, bus.flushPipe, bus.busy, bus.redirectTarget,
                 m_busy, m_exc, m_flush, m_tgt);
      end
      tick();
    end
    clear_reqs();
    $display("test_random done errors=%0d", failures - errs_before);
  endtask

  initial begin
    bus.stall = 0; bus.imemReady = 1; clear_reqs();
    test_reset();
    test_branch();
    test_stall();
    test_override();
    test_exception();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
